// File: rtl/mem_slave_pkg.sv
// Shared constants for the memory slave back-end: FSM state encoding,
// default burst-length width and the legal read-latency range.
package mem_slave_pkg;

    localparam int STATE_W = 3;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WRITE    = 3'd1;
    localparam logic [2:0] ST_RD_ISSUE = 3'd2;
    localparam logic [2:0] ST_RD_WAIT  = 3'd3;
    localparam logic [2:0] ST_RD_HOLD  = 3'd4;

    localparam int LEN_WIDTH_DEF = 4;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    // Wide enough to hold RD_LAT_MAX-1 wait cycles.
    localparam int LAT_CNT_W = $clog2(RD_LAT_MAX + 1);

endpackage

// File: rtl/mem_slave_ctrl_sp_ram.sv
// Single-port synchronous RAM with a RD_LATENCY-deep read pipeline.
// The array is never reset; only the controller state is.
module sp_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 2048,
    parameter int RD_LATENCY = 1,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q  [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] pipe_q [RD_LATENCY];

    // Stage 0 is the array read; later stages just delay the word.
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (en_i && !we_i) begin
            pipe_q[0] <= mem_q[addr_i];
        end
        for (int s = 1; s < RD_LATENCY; s++) begin
            pipe_q[s] <= pipe_q[s-1];
        end
    end

    assign rdata_o = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/mem_slave_ctrl.sv
// Burst memory controller between the bus slave core and an inferred RAM:
// range-checked commands, auto-increment addressing and held read beats.
module mem_slave_ctrl
    import mem_slave_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 12,
    parameter int DATA_WIDTH    = 8,
    parameter int MEM_DEPTH     = 2048,
    parameter int LEN_WIDTH     = LEN_WIDTH_DEF,
    parameter int RD_LATENCY    = 1,
    parameter int WRAP_EN       = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_wr,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]     cmd_len,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     addr_err,
    output logic                     busy,
    output logic [DATA_WIDTH-1:0]    disp_data,
    output logic [STATE_W-1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both high; rd_valid/rd_data never change while waiting.

    localparam int RAM_AW = $clog2(MEM_DEPTH);
    localparam logic [ADDRESS_WIDTH:0]   DEPTH_X   = (ADDRESS_WIDTH+1)'(MEM_DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEM_DEPTH - 1);
    localparam logic [LAT_CNT_W-1:0]     LAT_INIT  = LAT_CNT_W'(RD_LATENCY - 1);

    logic [STATE_W-1:0]       state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]     len_q, len_d;
    logic [LEN_WIDTH-1:0]     beat_q, beat_d;
    logic [LAT_CNT_W-1:0]     lat_q, lat_d;
    logic                     rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0]    disp_q, disp_d;
    logic                     err_q, err_d;

    logic [ADDRESS_WIDTH:0]   end_addr;
    logic                     range_bad;
    logic                     last_beat;
    logic [ADDRESS_WIDTH-1:0] addr_next;
    logic                     wr_fire;
    logic                     ram_en;
    logic [DATA_WIDTH-1:0]    ram_rdata;

    // One extra bit keeps cmd_addr+cmd_len from wrapping past the top.
    assign end_addr  = {1'b0, cmd_addr} + (ADDRESS_WIDTH+1)'(cmd_len);
    assign range_bad = ({1'b0, cmd_addr} >= DEPTH_X) ||
                       ((WRAP_EN == 0) && (end_addr >= DEPTH_X));
    assign last_beat = (beat_q == len_q);
    assign addr_next = ((WRAP_EN != 0) && (addr_q == LAST_ADDR)) ? '0 : addr_q + 1'b1;
    assign wr_fire   = (state_q == ST_WRITE) && wr_valid;
    assign ram_en    = wr_fire || (state_q == ST_RD_ISSUE);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        lat_d      = lat_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        disp_d     = disp_q;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (range_bad) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = cmd_addr;
                        len_d   = cmd_len;
                        beat_d  = '0;
                        state_d = cmd_wr ? ST_WRITE : ST_RD_ISSUE;
                    end
                end
            end
            ST_WRITE: begin
                if (wr_valid) begin
                    disp_d = wr_data;
                    addr_d = addr_next;
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RD_ISSUE: begin
                if (RD_LATENCY == 1) begin
                    state_d = ST_RD_HOLD;
                end else begin
                    state_d = ST_RD_WAIT;
                    lat_d   = LAT_INIT;
                end
            end
            ST_RD_WAIT: begin
                if (lat_q <= LAT_CNT_W'(1)) begin
                    state_d = ST_RD_HOLD;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            ST_RD_HOLD: begin
                // First cycle captures the RAM word; afterwards wait for rd_ready.
                if (!rd_valid_q) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = ram_rdata;
                    disp_d     = ram_rdata;
                end else if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_next;
                        beat_d  = beat_q + 1'b1;
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            lat_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            disp_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            lat_q      <= lat_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            disp_q     <= disp_d;
            err_q      <= err_d;
        end
    end

    sp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_ram (
        .clk_i   (clk),
        .en_i    (ram_en),
        .we_i    (wr_fire),
        .addr_i  (addr_q[RAM_AW-1:0]),
        .wdata_i (wr_data),
        .rdata_o (ram_rdata)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign wr_ready  = (state_q == ST_WRITE);
    assign busy      = (state_q != ST_IDLE);
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign disp_data = disp_q;
    assign addr_err  = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_slave_ctrl.sv
// Bench for mem_slave_ctrl: two instances (no-wrap/latency 1 and wrap/latency 3)
// checked against an array model of memory, a vector table and random bursts.
module tb_mem_slave_ctrl;
    import mem_slave_pkg::*;

    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 2048;
    localparam int LW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid [2];
    logic          cmd_wr    [2];
    logic [AW-1:0] cmd_addr  [2];
    logic [LW-1:0] cmd_len   [2];
    logic          wr_valid  [2];
    logic [DW-1:0] wr_data   [2];
    logic          rd_ready  [2];
    logic          cmd_ready [2];
    logic          wr_ready  [2];
    logic          rd_valid  [2];
    logic [DW-1:0] rd_data   [2];
    logic          addr_err  [2];
    logic          busy      [2];
    logic [DW-1:0] disp_data [2];
    logic [STATE_W-1:0] dbg_state [2];

    mem_slave_ctrl #(.WRAP_EN(0), .RD_LATENCY(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_wr(cmd_wr[0]),
        .cmd_addr(cmd_addr[0]), .cmd_len(cmd_len[0]),
        .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_data(wr_data[0]),
        .rd_valid(rd_valid[0]), .rd_ready(rd_ready[0]), .rd_data(rd_data[0]),
        .addr_err(addr_err[0]), .busy(busy[0]), .disp_data(disp_data[0]),
        .dbg_state(dbg_state[0])
    );

    mem_slave_ctrl #(.WRAP_EN(1), .RD_LATENCY(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_wr(cmd_wr[1]),
        .cmd_addr(cmd_addr[1]), .cmd_len(cmd_len[1]),
        .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_data(wr_data[1]),
        .rd_valid(rd_valid[1]), .rd_ready(rd_ready[1]), .rd_data(rd_data[1]),
        .addr_err(addr_err[1]), .busy(busy[1]), .disp_data(disp_data[1]),
        .dbg_state(dbg_state[1])
    );

    // Reference model: instance configuration and memory image.
    int          wrap_m [2] = '{0, 1};
    int          lat_m  [2] = '{1, 3};
    logic [DW-1:0] mem_m [2][DEPTH];

    logic [DW-1:0] exp_q  [$];
    logic [DW-1:0] wq     [$];
    logic [DW-1:0] rd_out [$];

    int checks = 0;
    int passes = 0;

    typedef struct {
        int inst;
        bit wr;
        int addr;
        int len;
        bit err;
    } vec_t;

    vec_t vt [12];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    function automatic bit model_err(int i, int a, int l);
        return (a >= DEPTH) || (wrap_m[i] == 0 && a + l >= DEPTH);
    endfunction

    function automatic int model_next(int i, int a);
        if (wrap_m[i] != 0 && a == DEPTH - 1) return 0;
        return a + 1;
    endfunction

    // Presents one command at a negedge; returns at the negedge after acceptance.
    task automatic send_cmd(int i, bit wr, int a, int l, bit exp_err);
        check("cmd_ready_idle", cmd_ready[i], 1);
        cmd_valid[i] = 1'b1;
        cmd_wr[i]    = wr;
        cmd_addr[i]  = AW'(a);
        cmd_len[i]   = LW'(l);
        @(negedge clk);
        cmd_valid[i] = 1'b0;
        check("addr_err", addr_err[i], exp_err);
        check("busy_after_cmd", busy[i], !exp_err);
        if (exp_err) begin
            @(negedge clk);
            check("addr_err_pulse_end", addr_err[i], 0);
            check("cmd_ready_after_err", cmd_ready[i], 1);
        end
    endtask

    // Write burst; data comes from wq. gap<0 means random 0..2 idle cycles per beat.
    task automatic do_write(int i, int a, int l, bit exp_err, int gap);
        int addr;
        int g;
        int n;
        logic [DW-1:0] d;
        d = '0;
        send_cmd(i, 1'b1, a, l, exp_err);
        if (exp_err) begin
            wr_valid[i] = 1'b1;
            wr_data[i]  = 8'hEE;
            @(negedge clk);
            check("wr_ready_idle", wr_ready[i], 0);
            wr_valid[i] = 1'b0;
            wq.delete();
            return;
        end
        addr = a;
        for (int b = 0; b <= l; b++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            repeat (g) @(negedge clk);
            d = (wq.size() > 0) ? wq.pop_front() : DW'($urandom);
            wr_valid[i] = 1'b1;
            wr_data[i]  = d;
            n = 0;
            while (!wr_ready[i] && n < 8) begin
                @(negedge clk);
                n++;
            end
            check("wr_ready_beat", wr_ready[i], 1);
            @(negedge clk);
            mem_m[i][addr] = d;
            addr = model_next(i, addr);
            wr_valid[i] = 1'b0;
        end
        check("busy_after_write", busy[i], 0);
        check("disp_after_write", disp_data[i], d);
    endtask

    // Read burst, results into rd_out. Optional stall on one beat and
    // optional cmd_valid poking while the controller is busy.
    task automatic do_read(int i, int a, int l, bit exp_err, int stall_beat, int stall_cyc, bit poke);
        int addr;
        int n;
        logic [DW-1:0] e;
        rd_out.delete();
        send_cmd(i, 1'b0, a, l, exp_err);
        if (exp_err) return;
        addr = a;
        for (int b = 0; b <= l; b++) begin
            exp_q.push_back(mem_m[i][addr]);
            n = 0;
            while (!rd_valid[i] && n < 12) begin
                if (poke && b == 0) begin
                    cmd_valid[i] = 1'b1;
                    cmd_wr[i]    = 1'b1;
                    cmd_addr[i]  = AW'(a);
                    cmd_len[i]   = '0;
                    check("cmd_ready_busy", cmd_ready[i], 0);
                end
                rd_ready[i] = 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
            end
            cmd_valid[i] = 1'b0;
            rd_ready[i]  = 1'b0;
            check("rd_latency", n, lat_m[i] + 1);
            e = exp_q.pop_front();
            check("rd_data", rd_data[i], e);
            check("disp_after_read", disp_data[i], e);
            rd_out.push_back(rd_data[i]);
            if (b == stall_beat) begin
                for (int s = 0; s < stall_cyc; s++) begin
                    @(negedge clk);
                    check("rd_valid_stall", rd_valid[i], 1);
                    check("rd_data_stall", rd_data[i], e);
                end
            end
            rd_ready[i] = 1'b1;
            @(negedge clk);
            rd_ready[i] = 1'b0;
            addr = model_next(i, addr);
        end
        check("busy_after_read", busy[i], 0);
        check("rd_valid_after_read", rd_valid[i], 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i, a, l;
        bit wr;
        logic [DW-1:0] old2, old3;

        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 1'b0; cmd_wr[k] = 1'b0; cmd_addr[k] = '0; cmd_len[k] = '0;
            wr_valid[k] = 1'b0; wr_data[k] = '0; rd_ready[k] = 1'b0;
        end

        vt[0]  = '{0, 1'b1, 'h7FE, 3,  1'b1};
        vt[1]  = '{0, 1'b0, 'h7FE, 1,  1'b0};
        vt[2]  = '{0, 1'b1, 'h7FF, 0,  1'b0};
        vt[3]  = '{0, 1'b0, 'h7F0, 15, 1'b0};
        vt[4]  = '{0, 1'b0, 'h7F1, 15, 1'b1};
        vt[5]  = '{0, 1'b1, 'h800, 0,  1'b1};
        vt[6]  = '{0, 1'b0, 'hFFF, 15, 1'b1};
        vt[7]  = '{1, 1'b1, 'h7FE, 3,  1'b0};
        vt[8]  = '{1, 1'b0, 'h800, 0,  1'b1};
        vt[9]  = '{1, 1'b0, 'hFFF, 1,  1'b1};
        vt[10] = '{1, 1'b1, 'h7FF, 15, 1'b0};
        vt[11] = '{1, 1'b0, 'h7F8, 15, 1'b0};

        // Reset state.
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_cmd_ready", cmd_ready[k], 1);
            check("rst_wr_ready", wr_ready[k], 0);
            check("rst_rd_valid", rd_valid[k], 0);
            check("rst_addr_err", addr_err[k], 0);
            check("rst_busy", busy[k], 0);
            check("rst_rd_data", rd_data[k], 0);
            check("rst_disp", disp_data[k], 0);
            check("rst_state", dbg_state[k], ST_IDLE);
        end
        rst = 1'b0;
        @(negedge clk);

        // Give the whole RAM of both instances a known image.
        for (int k = 0; k < 2; k++) begin
            for (int blk = 0; blk < DEPTH / 16; blk++) begin
                for (int b = 0; b < 16; b++) wq.push_back(DW'($urandom));
                do_write(k, blk * 16, 15, 1'b0, 0);
            end
        end

        // Single write then single read.
        wq = '{8'hA5};
        do_write(0, 'h010, 0, 1'b0, 0);
        do_read(0, 'h010, 0, 1'b0, -1, 0, 1'b0);
        check("t1_rd", rd_out[0], 8'hA5);
        check("t1_disp", disp_data[0], 8'hA5);

        // Burst of four with write gaps and a read stall on beat 2.
        wq = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_write(0, 'h100, 3, 1'b0, 2);
        do_read(0, 'h100, 3, 1'b0, 2, 3, 1'b0);
        check("t2_b0", rd_out[0], 8'h11);
        check("t2_b1", rd_out[1], 8'h22);
        check("t2_b2", rd_out[2], 8'h33);
        check("t2_b3", rd_out[3], 8'h44);

        // Vector table: range rules, boundary addresses and wrap.
        for (int v = 0; v < 12; v++) begin
            if (vt[v].wr) begin
                for (int b = 0; b <= vt[v].len; b++) wq.push_back(DW'($urandom));
                do_write(vt[v].inst, vt[v].addr, vt[v].len, vt[v].err, -1);
            end else begin
                do_read(vt[v].inst, vt[v].addr, vt[v].len, vt[v].err,
                        $urandom_range(0, vt[v].len), $urandom_range(0, 3), 1'b0);
            end
        end

        // Wrap-around write at the top of memory.
        wq = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        do_write(1, 'h7FE, 3, 1'b0, 0);
        do_read(1, 'h7FE, 3, 1'b0, -1, 0, 1'b0);
        check("t4_7fe", rd_out[0], 8'hB0);
        check("t4_7ff", rd_out[1], 8'hB1);
        check("t4_000", rd_out[2], 8'hB2);
        check("t4_001", rd_out[3], 8'hB3);
        do_read(1, 'h000, 1, 1'b0, -1, 0, 1'b0);
        check("t4_000_direct", rd_out[0], 8'hB2);
        check("t4_001_direct", rd_out[1], 8'hB3);

        // Latency-3 read with cmd_valid pulsed while busy.
        do_read(1, 'h200, 1, 1'b0, 0, 2, 1'b1);

        // Reset in the middle of a 4-beat write.
        old2 = mem_m[0]['h302];
        old3 = mem_m[0]['h303];
        send_cmd(0, 1'b1, 'h300, 3, 1'b0);
        for (int b = 0; b < 2; b++) begin
            wr_valid[0] = 1'b1;
            wr_data[0]  = DW'(8'hC0 + b);
            check("t5_wr_ready", wr_ready[0], 1);
            @(negedge clk);
            mem_m[0]['h300 + b] = DW'(8'hC0 + b);
        end
        wr_data[0] = 8'hC2;
        #2 rst = 1'b1;
        #1;
        check("t5_busy", busy[0], 0);
        check("t5_wr_ready_rst", wr_ready[0], 0);
        check("t5_rd_valid", rd_valid[0], 0);
        check("t5_cmd_ready", cmd_ready[0], 1);
        check("t5_disp", disp_data[0], 0);
        wr_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_read(0, 'h300, 3, 1'b0, -1, 0, 1'b0);
        check("t5_b0", rd_out[0], 8'hC0);
        check("t5_b1", rd_out[1], 8'hC1);
        check("t5_b2_old", rd_out[2], old2);
        check("t5_b3_old", rd_out[3], old3);

        // Random commands on both instances.
        for (int r = 0; r < 60; r++) begin
            i  = r % 2;
            wr = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4095))
                                             : int'($urandom_range(0, 2047));
            l  = $urandom_range(0, 15);
            if (wr) begin
                for (int b = 0; b <= l; b++) wq.push_back(DW'($urandom));
                do_write(i, a, l, model_err(i, a, l), -1);
            end else begin
                do_read(i, a, l, model_err(i, a, l), $urandom_range(0, l),
                        $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
